meco_cmd_engine: RTL and testbench

//  Parametrised command engine between the shared SRAM mailbox and the pin drivers.

---
 rtl/meco_cmd_engine_if.sv | 29 ++
 rtl/meco_cmd_engine.sv | 198 +++++++++++++++++++
 tb/tb_meco_cmd_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/meco_cmd_engine_if.sv
// Shared-SRAM mailbox port of the command engine.
// The engine drives address, write data and strobes. The RAM side returns read
// data one cycle after a read strobe.
interface meco_cmd_engine_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_wr;
    logic              ram_en;

    modport master (
        output ram_addr,
        output ram_data_out,
        output ram_wr,
        output ram_en,
        input  ram_data_in
    );

    modport slave (
        input  ram_addr,
        input  ram_data_out,
        input  ram_wr,
        input  ram_en,
        output ram_data_in
    );
endinterface

// File: rtl/meco_cmd_engine.sv
// Mailbox-driven command engine between the shared SRAM and the pin drivers.
// The engine polls the instruction word at CMD_BASE and fetches the optional data
// word at CMD_BASE+1. It runs pin program, read-back and bank-write commands.
// When a command finishes, the engine writes its status back to CMD_BASE.
module meco_cmd_engine #(
    parameter int                ADDR_W   = 21,
    parameter int                DATA_W   = 16,
    parameter int                NUM_PINS = 16,
    parameter logic [ADDR_W-1:0] CMD_BASE = ADDR_W'(15),
    parameter int                POLL_DIV = 8
) (
    input  logic                clk,
    input  logic                reset,
    meco_cmd_engine_if.master   ram,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic                busy
);

    localparam int                CNT_W     = $clog2(POLL_DIV + 1);
    localparam int                NUM_BANKS = NUM_PINS / 16;
    localparam logic [8:0]        PIN_LIM   = 9'(NUM_PINS);
    localparam logic [8:0]        BANK_LIM  = 9'(NUM_BANKS);
    localparam logic [ADDR_W-1:0] DATA_ADDR = CMD_BASE + ADDR_W'(1);

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET_PIN    = 3'd1,
        OP_READ_PIN   = 3'd2,
        OP_WRITE_BANK = 3'd3,
        OP_CLEAR_ALL  = 3'd4
    } opcode_t;

    typedef enum logic [8:0] {
        S_IDLE    = 9'b000000001,
        S_FETCH_I = 9'b000000010,
        S_WAIT_I  = 9'b000000100,
        S_DECODE  = 9'b000001000,
        S_FETCH_D = 9'b000010000,
        S_WAIT_D  = 9'b000100000,
        S_EXEC    = 9'b001000000,
        S_RDBK    = 9'b010000000,
        S_ACK     = 9'b100000000
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  poll_cnt_q;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    opcode_t           opcode;
    logic [7:0]        idx;
    logic              cmd_bad;
    logic              rd_bit;
    logic [15:0]       ack_word;
    logic              unused_err_field;

    assign opcode           = opcode_t'(instr_q[13:11]);
    assign idx              = instr_q[7:0];
    assign busy             = (state_q != S_IDLE);
    // The host-written ERR bit is never read: the engine always reports its own.
    assign unused_err_field = instr_q[14];

    // Detect commands that cannot run: illegal opcodes or an index outside the pin/bank range.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cmd_bad = 1'b0;
        case (opcode)
            OP_NOP, OP_CLEAR_ALL:    cmd_bad = 1'b0;
            OP_SET_PIN, OP_READ_PIN: cmd_bad = ({1'b0, idx} >= PIN_LIM);
            OP_WRITE_BANK:           cmd_bad = ({1'b0, idx} >= BANK_LIM);
            default:                 cmd_bad = 1'b1;
        endcase
    end

    // Select the addressed input pin for read-back and build the status word for the ack.
    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (idx == 8'(i)) rd_bit = pin_in[i];
        end
        // On the DECODE->ACK error path err_q is not loaded yet, so use the live check.
        ack_word = {1'b0, (state_q == S_DECODE) ? cmd_bad : err_q, instr_q[13:0]};
    end

    // Compute the next state: poll the mailbox, then run one command and acknowledge it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (poll_cnt_q == CNT_W'(1)) state_d = S_FETCH_I;
            S_FETCH_I: state_d = S_WAIT_I;
            S_WAIT_I:  state_d = S_DECODE;
            S_DECODE: begin
                if (!instr_q[15]) begin
                    state_d = S_IDLE;
                end else if (cmd_bad) begin
                    state_d = S_ACK;
                end else begin
                    case (opcode)
                        OP_SET_PIN, OP_WRITE_BANK: state_d = S_FETCH_D;
                        OP_READ_PIN:               state_d = S_RDBK;
                        default:                   state_d = S_EXEC;
                    endcase
                end
            end
            S_FETCH_D: state_d = S_WAIT_D;
            S_WAIT_D:  state_d = S_EXEC;
            S_EXEC:    state_d = S_ACK;
            S_RDBK:    state_d = S_ACK;
            S_ACK:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Hold the state register. Reset aborts any command that is in progress.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Count down the poll interval while idle. Reload it in every other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 poll_cnt_q <= CNT_W'(POLL_DIV);
        else if (state_q == S_IDLE) poll_cnt_q <= poll_cnt_q - CNT_W'(1);
        else                        poll_cnt_q <= CNT_W'(POLL_DIV);
    end

    // Register the RAM strobes from the next state, so each access is driven during its own state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram.ram_en       <= 1'b0;
            ram.ram_wr       <= 1'b0;
            ram.ram_addr     <= CMD_BASE;
            ram.ram_data_out <= '0;
        end else begin
            ram.ram_en       <= 1'b0;
            ram.ram_wr       <= 1'b0;
            ram.ram_addr     <= CMD_BASE;
            ram.ram_data_out <= '0;
            case (state_d)
                S_FETCH_I: begin
                    ram.ram_en <= 1'b1;
                end
                S_FETCH_D: begin
                    ram.ram_en   <= 1'b1;
                    ram.ram_addr <= DATA_ADDR;
                end
                S_RDBK: begin
                    // The pin level is captured on the edge that enters RDBK.
                    ram.ram_en       <= 1'b1;
                    ram.ram_wr       <= 1'b1;
                    ram.ram_addr     <= DATA_ADDR;
                    ram.ram_data_out <= DATA_W'(rd_bit);
                end
                S_ACK: begin
                    ram.ram_en       <= 1'b1;
                    ram.ram_wr       <= 1'b1;
                    ram.ram_data_out <= DATA_W'(ack_word);
                end
                default: ;
            endcase
        end
    end

    // Capture the instruction, the data word and the error flag, and update the pins in EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pin_out <= '0;
        end else begin
            if (state_q == S_WAIT_I) instr_q <= ram.ram_data_in[15:0];
            if (state_q == S_WAIT_D) data_q  <= ram.ram_data_in;
            if (state_q == S_DECODE) err_q   <= cmd_bad;
            if (state_q == S_EXEC) begin
                case (opcode)
                    OP_SET_PIN: begin
                        for (int i = 0; i < NUM_PINS; i++) begin
                            if (idx == 8'(i)) pin_out[i] <= data_q[0];
                        end
                    end
                    OP_WRITE_BANK: begin
                        for (int b = 0; b < NUM_BANKS; b++) begin
                            if (idx == 8'(b)) pin_out[b*16 +: 16] <= data_q[15:0];
                        end
                    end
                    OP_CLEAR_ALL: pin_out <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_meco_cmd_engine.sv
// Directed bench for meco_cmd_engine. It runs two engines (16 and 32 pins) on
// behavioural mailbox RAMs.
// The bench covers polling, SET_PIN latency, read-back, error acks, bank writes
// and reset in mid-command.
module tb_meco_cmd_engine;

    localparam int          AW   = 21;
    localparam int          DW   = 16;
    localparam int          POLL = 4;
    localparam logic [20:0] BASE = 21'hF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    meco_cmd_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    meco_cmd_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    logic [15:0] pin_in0, pin_out0;
    logic [31:0] pin_in1, pin_out1;
    logic        busy0, busy1;

    meco_cmd_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_PINS(16), .CMD_BASE(BASE), .POLL_DIV(POLL)) u_dut0 (
        .clk(clk), .reset(reset), .ram(bus0), .pin_in(pin_in0), .pin_out(pin_out0), .busy(busy0)
    );

    meco_cmd_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_PINS(32), .CMD_BASE(BASE), .POLL_DIV(POLL)) u_dut1 (
        .clk(clk), .reset(reset), .ram(bus1), .pin_in(pin_in1), .pin_out(pin_out1), .busy(busy1)
    );

    // Mailbox RAMs: host writes and engine accesses. The engine write wins a same-edge collision.
    logic [15:0] mem0 [32] = '{default: 16'h0000};
    logic [15:0] mem1 [32] = '{default: 16'h0000};
    logic        h_we  = 1'b0;
    logic        h_sel = 1'b0;
    logic [4:0]  h_addr = '0;
    logic [15:0] h_data = '0;
    int          wr_total0 = 0;
    int          wr_data0  = 0;

    always @(posedge clk) begin
        if (h_we && !h_sel) mem0[h_addr] <= h_data;
        if (h_we &&  h_sel) mem1[h_addr] <= h_data;
        if (bus0.ram_en) begin
            if (bus0.ram_wr) begin
                mem0[bus0.ram_addr[4:0]] <= bus0.ram_data_out;
                wr_total0 <= wr_total0 + 1;
                if (bus0.ram_addr == BASE + 21'd1) wr_data0 <= wr_data0 + 1;
            end else begin
                bus0.ram_data_in <= mem0[bus0.ram_addr[4:0]];
            end
        end
        if (bus1.ram_en) begin
            if (bus1.ram_wr) mem1[bus1.ram_addr[4:0]] <= bus1.ram_data_out;
            else             bus1.ram_data_in <= mem1[bus1.ram_addr[4:0]];
        end
    end

    // Timing monitor for engine 0: fetch cycles, ack cycle, pin change cycle, busy pulse width.
    int          cyc = 0, fetch_prev = 0, fetch_last = 0, ack_cyc = 0, pin_chg = 0;
    int          busy_run = 0, busy_len = 0;
    logic [15:0] pin_prev = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus0.ram_en && !bus0.ram_wr && bus0.ram_addr == BASE) begin
            fetch_prev <= fetch_last;
            fetch_last <= cyc;
        end
        if (bus0.ram_en && bus0.ram_wr && bus0.ram_addr == BASE) ack_cyc <= cyc;
        if (pin_out0 !== pin_prev) pin_chg <= cyc;
        pin_prev <= pin_out0;
        if (busy0) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_len <= busy_run;
            busy_run <= 0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic sel, input logic [4:0] addr, input logic [15:0] data);
        @(negedge clk);
        h_we = 1'b1; h_sel = sel; h_addr = addr; h_data = data;
        @(negedge clk);
        h_we = 1'b0;
    endtask

    // Wait until the engine clears GO in the mailbox, with a cycle budget.
    task automatic wait_done(input logic sel, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = sel ? !mem1[15][15] : !mem0[15][15];
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Post a command to engine 0 and check the ack word and the pin state.
    task automatic cmd0(input logic [15:0] mbox, input logic [15:0] ack, input logic [15:0] pins, input string tag);
        host_wr(1'b0, 5'd15, mbox);
        wait_done(1'b0, tag);
        check({tag, "_ack"}, 32'(mem0[15]), 32'(ack));
        check({tag, "_pins"}, 32'(pin_out0), 32'(pins));
    endtask

    initial begin
        int   d;
        logic found;
        pin_in0 = '0;
        pin_in1 = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pin_out", 32'(pin_out0), 32'h0);
        check("rst_ram_en", 32'(bus0.ram_en), 32'h0);
        check("rst_ram_wr", 32'(bus0.ram_wr), 32'h0);
        check("rst_ram_addr", 32'(bus0.ram_addr), 32'hF);
        check("rst_ram_dout", 32'(bus0.ram_data_out), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);

        // Empty mailbox: poll period POLL+3, 3-cycle busy pulses, no writes.
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("poll_period", 32'(fetch_last - fetch_prev), 32'(POLL + 3));
        check("busy_pulse", 32'(busy_len), 32'd3);
        check("idle_no_writes", 32'(wr_total0), 32'd0);
        check("idle_pins", 32'(pin_out0), 32'h0);

        // SET_PIN index 5 to 1; check the latency from fetch to pin change and to ack.
        host_wr(1'b0, 5'd16, 16'h0001);
        cmd0(16'h8805, 16'h0805, 16'h0020, "set5");
        check("set_pin_latency", 32'(pin_chg - fetch_last), 32'd6);
        check("set_ack_latency", 32'(ack_cyc - fetch_last), 32'd6);

        // READ_PIN reads back a high pin and a low pin.
        pin_in0 = 16'h0100;
        host_wr(1'b0, 5'd16, 16'hFFFF);
        d = wr_data0;
        cmd0(16'h9008, 16'h1008, 16'h0020, "rd8");
        check("rd8_data", 32'(mem0[16]), 32'h0001);
        check("rd8_data_writes", 32'(wr_data0 - d), 32'd1);
        host_wr(1'b0, 5'd16, 16'hFFFF);
        cmd0(16'h9003, 16'h1003, 16'h0020, "rd3");
        check("rd3_data", 32'(mem0[16]), 32'h0000);

        // Error commands do not change the pins and do not write the data word.
        host_wr(1'b0, 5'd16, 16'h0001);
        d = wr_data0;
        cmd0(16'h8814, 16'h4814, 16'h0020, "err_idx20");
        cmd0(16'h8810, 16'h4810, 16'h0020, "err_idx16");
        cmd0(16'h9010, 16'h5010, 16'h0020, "err_rd16");
        cmd0(16'h9801, 16'h5801, 16'h0020, "err_bank1");
        cmd0(16'hB800, 16'h7800, 16'h0020, "err_op7");
        check("err_no_data_write", 32'(wr_data0 - d), 32'd0);
        check("err_data_word", 32'(mem0[16]), 32'h0001);

        // Valid edge cases: highest pin index and NOP.
        cmd0(16'h880F, 16'h080F, 16'h8020, "set15");
        cmd0(16'h8000, 16'h0000, 16'h8020, "nop");

        // 32-pin engine: bank write, bank index out of range, then CLEAR_ALL.
        host_wr(1'b1, 5'd16, 16'hA5A5);
        host_wr(1'b1, 5'd15, 16'h9801);
        wait_done(1'b1, "bank1");
        check("bank1_ack", 32'(mem1[15]), 32'h1801);
        check("bank1_pins", pin_out1, 32'hA5A5_0000);
        host_wr(1'b1, 5'd15, 16'h9802);
        wait_done(1'b1, "bank2");
        check("bank2_ack", 32'(mem1[15]), 32'h5802);
        check("bank2_pins", pin_out1, 32'hA5A5_0000);
        host_wr(1'b1, 5'd15, 16'hA000);
        wait_done(1'b1, "clear");
        check("clear_ack", 32'(mem1[15]), 32'h2000);
        check("clear_pins", pin_out1, 32'h0);

        // Reset during FETCH_D of a SET_PIN: outputs clear at once, then the command runs again.
        host_wr(1'b0, 5'd16, 16'h0001);
        host_wr(1'b0, 5'd15, 16'h8803);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = bus0.ram_en && !bus0.ram_wr && (bus0.ram_addr == BASE + 21'd1);
        end
        check("fetch_d_seen", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_ram_en", 32'(bus0.ram_en), 32'h0);
        check("mid_rst_ram_wr", 32'(bus0.ram_wr), 32'h0);
        check("mid_rst_busy", 32'(busy0), 32'h0);
        check("mid_rst_pins", 32'(pin_out0), 32'h0);
        check("mid_rst_addr", 32'(bus0.ram_addr), 32'hF);
        repeat (3) @(negedge clk);
        check("mid_rst_no_ack", 32'(mem0[15]), 32'h8803);
        reset = 1'b1;
        wait_done(1'b0, "reexec");
        check("reexec_ack", 32'(mem0[15]), 32'h0803);
        check("reexec_pins", 32'(pin_out0), 32'h0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
